mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 13 +
 rtl/mem_access_unit_bus_timeout_counter.sv | 39 +++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions for the memory access unit: bus width, parameter defaults
// and FSM state encodings.
package mem_access_unit_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned DMEM_WORDS_DEFAULT  = 128;
    localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_access_unit_bus_timeout_counter.sv
// Counts WAIT cycles of an external access; expired marks the last allowed WAIT cycle.
module bus_timeout_counter
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th WAIT cycle.
    assign expired = en & (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: zero-latency internal data memory, multi-cycle external bus
// access with stall, timeout and sticky error flag.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DMEM_WORDS  = DMEM_WORDS_DEFAULT,
    parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic            we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_data,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_q,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_data,
    output logic            bus_we,
    output logic            bus_start,
    input  logic            bus_done,
    input  logic [XLEN-1:0] bus_q,
    output logic [XLEN-1:0] q,
    output logic            busy,
    output logic            err
);

    logic [1:0]      state_q,     state_d;
    logic [XLEN-1:0] bus_addr_q,  bus_addr_d;
    logic [XLEN-1:0] bus_data_q,  bus_data_d;
    logic            bus_we_q,    bus_we_d;
    logic            bus_start_q, bus_start_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            err_q,       err_d;
    logic            internal;
    logic            tmo_expired;
    logic            busy_raw;

    assign internal  = addr < XLEN'(DMEM_WORDS);
    assign dmem_addr = addr;
    assign dmem_data = wdata;
    assign dmem_we   = we & internal & ~reset;

    bus_timeout_counter #(
        .TIMEOUT (BUS_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .expired (tmo_expired)
    );

    // Next-state, bus-request latching and pipeline-facing outputs.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        bus_we_d    = bus_we_q;
        bus_start_d = 1'b0;
        result_d    = result_q;
        err_d       = err_q;
        busy_raw    = 1'b0;
        q           = dmem_q;
        case (state_q)
            ST_IDLE: begin
                if ((re | we) & ~internal) begin
                    busy_raw    = 1'b1;
                    state_d     = ST_WAIT;
                    bus_addr_d  = addr;
                    bus_data_d  = wdata;
                    bus_we_d    = we;
                    bus_start_d = 1'b1;
                end
            end
            ST_WAIT: begin
                busy_raw = 1'b1;
                // A completion in the timeout cycle still counts as success.
                if (bus_done) begin
                    state_d  = ST_DONE;
                    result_d = bus_we_q ? '0 : bus_q;
                end else if (tmo_expired) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_DONE: begin
                q       = result_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = busy_raw & ~reset;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign bus_we    = bus_we_q;
    assign bus_start = bus_start_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_start_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_we_q    <= bus_we_d;
            bus_start_q <= bus_start_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized mix
// checked against a transaction-level model of memory contents, latency and error state.
module tb_mem_access_unit;

    localparam int unsigned TO    = 4;
    localparam int unsigned WORDS = 128;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        re, we;
    logic [31:0] dmem_addr, dmem_data, dmem_q;
    logic        dmem_we;
    logic [31:0] bus_addr, bus_data, bus_q, q;
    logic        bus_we, bus_start, bus_done, busy, err;

    int          n_checks;
    int          n_fail;
    logic        err_exp;
    logic [31:0] ref_mem  [WORDS];
    logic [31:0] stub_mem [WORDS];

    mem_access_unit #(
        .DMEM_WORDS  (WORDS),
        .BUS_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .re        (re),
        .we        (we),
        .dmem_addr (dmem_addr),
        .dmem_data (dmem_data),
        .dmem_we   (dmem_we),
        .dmem_q    (dmem_q),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_we    (bus_we),
        .bus_start (bus_start),
        .bus_done  (bus_done),
        .bus_q     (bus_q),
        .q         (q),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory stand-in, written only through the DUT's dmem port.
    always @(posedge clk) if (dmem_we) stub_mem[dmem_addr[6:0]] <= dmem_data;
    assign dmem_q = stub_mem[dmem_addr[6:0]];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; re = 1'b0; we = 1'b1; addr = 32'd5; wdata = $urandom;
        bus_done = 1'b0; bus_q = '0;
        tick;
        sample;
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_we got %0b exp 0", dmem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b exp 0", busy); end
        tick;
        reset = 1'b0; we = 1'b0;
        err_exp = 1'b0;
        sample;
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL rst_bus_start got %0b exp 0", bus_start); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we got %0b exp 0", bus_we); end
        n_checks++; if (bus_addr !== 32'd0) begin n_fail++; $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
        n_checks++; if (bus_data !== 32'd0) begin n_fail++; $display("FAIL rst_bus_data got %h exp 0", bus_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b exp 0", err); end
        n_checks++; if (q !== ref_mem[5]) begin n_fail++; $display("FAIL rst_q got %h exp %h", q, ref_mem[5]); end
    endtask

    task automatic test_internal(input bit store, input logic [31:0] a, input logic [31:0] d);
        tick;
        bus_done = 1'b0;
        addr = a; wdata = d; we = store; re = ~store;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL int_busy got %0b exp 0", busy); end
        n_checks++; if (dmem_we !== store) begin n_fail++; $display("FAIL int_dmem_we got %0b exp %0b", dmem_we, store); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL int_bus_start got %0b exp 0", bus_start); end
        if (store) begin
            ref_mem[a[6:0]] = d;
        end else begin
            n_checks++; if (q !== ref_mem[a[6:0]]) begin n_fail++; $display("FAIL int_load_q addr %0d got %h exp %h", a, q, ref_mem[a[6:0]]); end
        end
    endtask

    // k: WAIT cycle (1-based) in which bus_done pulses; outside 1..TO means never.
    task automatic test_external(input bit st, input bit both, input logic [31:0] a,
                                 input logic [31:0] d, input int k, input logic [31:0] rd);
        bit          store;
        bit          timeout;
        int          n;
        logic [31:0] exp_q;
        store   = st | both;
        timeout = (k < 1) || (k > int'(TO));
        n       = timeout ? int'(TO) : k;
        exp_q   = (store || timeout) ? 32'd0 : rd;
        tick;
        bus_done = 1'b0;
        addr = a; wdata = d; we = store; re = ~st | both;
        sample;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ext_req_busy got %0b exp 1", busy); end
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL ext_dmem_we got %0b exp 0", dmem_we); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL ext_early_start got %0b exp 0", bus_start); end
        for (int i = 1; i <= n; i++) begin
            tick;
            bus_done = (i == k);
            bus_q    = (i == k) ? rd : $urandom;
            sample;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy cyc %0d got %0b exp 1", i, busy); end
            n_checks++; if (bus_start !== (i == 1)) begin n_fail++; $display("FAIL wait_bus_start cyc %0d got %0b exp %0b", i, bus_start, i == 1); end
            n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL wait_dmem_we cyc %0d got %0b exp 0", i, dmem_we); end
            if (i == 1) begin
                n_checks++; if (bus_addr !== a) begin n_fail++; $display("FAIL bus_addr got %h exp %h", bus_addr, a); end
                n_checks++; if (bus_data !== d) begin n_fail++; $display("FAIL bus_data got %h exp %h", bus_data, d); end
                n_checks++; if (bus_we !== store) begin n_fail++; $display("FAIL bus_we got %0b exp %0b", bus_we, store); end
            end
        end
        tick;
        bus_done = 1'b0;
        bus_q    = $urandom;
        if (timeout) err_exp = 1'b1;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy got %0b exp 0", busy); end
        n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL done_q got %h exp %h", q, exp_q); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL done_bus_start got %0b exp 0", bus_start); end
        n_checks++; if (err !== err_exp) begin n_fail++; $display("FAIL done_err got %0b exp %0b", err, err_exp); end
        re = 1'b0; we = 1'b0;
        tick;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_busy got %0b exp 0", busy); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL post_bus_start got %0b exp 0", bus_start); end
    endtask

    task automatic test_idle(input bit pulse_done);
        logic [31:0] a;
        a = 32'($urandom_range(0, WORDS - 1));
        tick;
        re = 1'b0; we = 1'b0; addr = a; bus_done = pulse_done; bus_q = $urandom;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b exp 0", busy); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL idle_bus_start got %0b exp 0", bus_start); end
        n_checks++; if (q !== ref_mem[a[6:0]]) begin n_fail++; $display("FAIL idle_q got %h exp %h", q, ref_mem[a[6:0]]); end
        n_checks++; if (err !== err_exp) begin n_fail++; $display("FAIL idle_err got %0b exp %0b", err, err_exp); end
    endtask

    task automatic test_reset_in_wait;
        tick;
        bus_done = 1'b0; addr = 32'h4000; re = 1'b1; we = 1'b0;
        sample;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_req_busy got %0b exp 1", busy); end
        tick;
        tick;
        reset = 1'b1;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy_in_reset got %0b exp 0", busy); end
        tick;
        reset = 1'b0; re = 1'b0; addr = 32'd5; bus_done = 1'b1; bus_q = 32'hCAFE_F00D;
        err_exp = 1'b0;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy got %0b exp 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rw_err got %0b exp 0", err); end
        n_checks++; if (bus_start !== 1'b0) begin n_fail++; $display("FAIL rw_bus_start got %0b exp 0", bus_start); end
        n_checks++; if (q !== ref_mem[5]) begin n_fail++; $display("FAIL rw_q got %h exp %h", q, ref_mem[5]); end
        tick;
        bus_done = 1'b0;
        sample;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_late_busy got %0b exp 0", busy); end
        n_checks++; if (q !== ref_mem[5]) begin n_fail++; $display("FAIL rw_late_q got %h exp %h", q, ref_mem[5]); end
    endtask

    task automatic test_random(input int count);
        for (int t = 0; t < count; t++) begin
            case ($urandom_range(0, 3))
                0: test_internal(1'b0, 32'($urandom_range(0, WORDS - 1)), 32'd0);
                1: test_internal(1'b1, 32'($urandom_range(0, WORDS - 1)), $urandom);
                2: test_external(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 32'(WORDS) + 32'($urandom_range(0, 32'h00FF_FFFF)),
                                 $urandom, int'($urandom_range(1, TO + 2)), $urandom);
                default: test_idle(1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        err_exp  = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            ref_mem[i]  = '0;
            stub_mem[i] = '0;
        end
        test_reset;
        test_internal(1'b1, 32'd5, 32'hDEAD_BEEF);
        test_internal(1'b0, 32'd5, 32'd0);
        test_internal(1'b1, 32'd127, 32'h0BAD_F00D);
        test_internal(1'b0, 32'd127, 32'd0);
        test_external(1'b0, 1'b0, 32'h1000, $urandom, 3, 32'h1234_5678);
        test_external(1'b1, 1'b0, 32'h2000, 32'hA5A5_A5A5, 2, 32'hFFFF_FFFF);
        test_external(1'b0, 1'b1, 32'h1000, 32'h5555_AAAA, 1, 32'h7777_7777);
        test_external(1'b0, 1'b0, 32'd128, $urandom, int'(TO), 32'h600D_600D);
        test_idle(1'b1);
        test_external(1'b0, 1'b0, 32'h3000, $urandom, 0, 32'h1111_1111);
        test_idle(1'b0);
        test_internal(1'b0, 32'd5, 32'd0);
        test_external(1'b0, 1'b0, 32'h3004, $urandom, 1, 32'h2222_2222);
        test_reset_in_wait;
        test_random(80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
